// File: rtl/glyph_scan_display.sv
// glyph_scan_display
//   Drives an N_DIGITS-digit multiplexed 7-segment display. One glyph code and one blink bit
//   are held per digit. Digits are lit one at a time, each for SCAN_DIV clocks. Blinking digits
//   go dark during the off half of a blink period, which lasts BLINK_DIV full rotations.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   wr_en      write strobe; stores {wr_blink, wr_glyph} into digit wr_digit
//   wr_digit   target digit (0 = leftmost); out-of-range indices are ignored
//   wr_glyph   glyph code to store
//   wr_blink   blink enable stored with the glyph
//   blank_all  force seg/an to zero while high (internal state keeps running)
//   seg        registered segment pattern, bit 6..0, 1 = lit
//   an         registered one-hot digit enable, 1 = lit
//   scan_tick  combinational pulse on the last count of each digit slot
module glyph_scan_display #(
    parameter int unsigned N_DIGITS  = 4,
    parameter int unsigned GLYPH_W   = 3,
    parameter int unsigned SCAN_DIV  = 16,
    parameter int unsigned BLINK_DIV = 8,
    localparam int unsigned PTR_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [PTR_W-1:0]    wr_digit,
    input  logic [GLYPH_W-1:0]  wr_glyph,
    input  logic                wr_blink,
    input  logic                blank_all,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] an,
    output logic                scan_tick
);

    localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
    localparam logic [PTR_W-1:0]   PTR_LAST    = PTR_W'(N_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);
    localparam logic [GLYPH_W-1:0] GLYPH_BLANK = GLYPH_W'(7);

    logic [GLYPH_W-1:0]  mem_q [N_DIGITS];
    logic [N_DIGITS-1:0] blink_q;

    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                phase_on_q, phase_on_d;

    logic [6:0]          seg_q, seg_d;
    logic [N_DIGITS-1:0] an_q, an_d;

    logic [GLYPH_W-1:0]  cur_glyph;
    logic                cur_blink;
    logic [N_DIGITS-1:0] cur_onehot;

    // Glyph table; every code outside 0..6 renders blank.
    function automatic logic [6:0] glyph_seg(input logic [GLYPH_W-1:0] code);
        logic [6:0] s;
        s = 7'b000_0000;
        case (code)
            GLYPH_W'(0): s = 7'b011_1110; // U
            GLYPH_W'(1): s = 7'b000_0110; // i
            GLYPH_W'(2): s = 7'b110_0111; // P
            GLYPH_W'(3): s = 7'b100_0111; // F
            GLYPH_W'(4): s = 7'b100_1111; // E
            GLYPH_W'(5): s = 7'b000_1000; // up
            GLYPH_W'(6): s = 7'b100_0000; // down
            default:     s = 7'b000_0000;
        endcase
        return s;
    endfunction

    // Glyph memory. Loop-compare decode means an index >= N_DIGITS matches nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_DIGITS); i++) begin
                mem_q[i] <= GLYPH_BLANK;
            end
            blink_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < int'(N_DIGITS); i++) begin
                if (wr_digit == PTR_W'(i)) begin
                    mem_q[i]   <= wr_glyph;
                    blink_q[i] <= wr_blink;
                end
            end
        end
    end

    assign scan_tick = (scan_cnt_q == SCAN_LAST);

    always_comb begin
        scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
        ptr_d       = ptr_q;
        blink_cnt_d = blink_cnt_q;
        phase_on_d  = phase_on_q;
        if (scan_tick) begin
            scan_cnt_d = '0;
            ptr_d      = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
            // Blink timing advances once per full rotation.
            if (ptr_q == PTR_LAST) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d = '0;
                    phase_on_d  = ~phase_on_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            ptr_q       <= '0;
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            ptr_q       <= ptr_d;
            blink_cnt_q <= blink_cnt_d;
            phase_on_q  <= phase_on_d;
        end
    end

    // Select the current digit by compare rather than array index so N_DIGITS == 1 stays clean.
    always_comb begin
        cur_glyph  = GLYPH_BLANK;
        cur_blink  = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (ptr_q == PTR_W'(i)) begin
                cur_glyph     = mem_q[i];
                cur_blink     = blink_q[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    // During blink-off the anode stays on; only the segments go dark.
    always_comb begin
        an_d  = blank_all ? '0 : cur_onehot;
        seg_d = glyph_seg(cur_glyph);
        if (blank_all || (cur_blink && !phase_on_q)) begin
            seg_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= '0;
            an_q  <= '0;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule
